// File: rtl/prime_pkg.sv
// prime_pkg: shared types and constants for the sequential prime generator.
// Optional feature macro used by the generator files: PRIME_GEN_COUNT_EN.
package prime_pkg;

    // Controller states of the sweep. The top maps these onto plain
    // localparam codes so the state register stays a simple logic vector.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } prime_gen_state_t;

    // Default candidate/output width in bits.
    localparam int PRIME_GEN_WIDTH_DEFAULT = 4;

    // Number of primes below 2^w, used only as a documentation aid for
    // integrators sizing downstream buffers (small widths only).
    function automatic int unsigned prime_gen_count_below(input int unsigned w);
        int unsigned cnt;
        bit          is_p;
        cnt = 0;
        for (int unsigned n = 2; n < (32'd1 << w); n++) begin
            is_p = 1'b1;
            for (int unsigned k = 2; k * k <= n; k++) begin
                if ((n % k) == 0) begin
                    is_p = 1'b0;
                end
            end
            if (is_p) begin
                cnt++;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prime_gen_if.sv
// prime_gen_if: control and valid/ready output stream of prime_gen.
// When PRIME_GEN_COUNT_EN is defined the bus also carries prime_count.
interface prime_gen_if
    import prime_pkg::*;
#(
    parameter int WIDTH = PRIME_GEN_WIDTH_DEFAULT
) ();

    logic             start;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             done;
`ifdef PRIME_GEN_COUNT_EN
    logic [WIDTH-1:0] prime_count;
`endif

    // Generator side: produces the prime stream and status.
    modport master (
        input  start,
        input  out_ready,
        output out_valid,
        output out_data,
        output busy,
        output done
`ifdef PRIME_GEN_COUNT_EN
        ,
        output prime_count
`endif
    );

    // Consumer side: starts sweeps and accepts primes.
    modport slave (
        output start,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  busy,
        input  done
`ifdef PRIME_GEN_COUNT_EN
        ,
        input  prime_count
`endif
    );

endinterface

// File: rtl/prime_trial_step.sv
// prime_trial_step: one trial-division step for candidate n and divisor d.
// sq_gt means no divisor up to sqrt(n) remains, so n is prime;
// divides means d is a factor of n.
module prime_trial_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    output logic             sq_gt,
    output logic             divides
);

    logic [2*WIDTH-1:0] d_wide;
    logic [2*WIDTH-1:0] n_wide;
    logic [2*WIDTH-1:0] d_sq;
    logic [WIDTH-1:0]   rem;

    // Square at double width so d*d never overflows; guard d=0 for the remainder.
    always_comb begin
        d_wide  = {{WIDTH{1'b0}}, d};
        n_wide  = {{WIDTH{1'b0}}, n};
        d_sq    = d_wide * d_wide;
        sq_gt   = (d_sq > n_wide);
        rem     = (d != '0) ? (n % d) : n;
        divides = (d != '0) && (rem == '0);
    end

endmodule

// File: rtl/prime_gen.sv
// prime_gen: sweeps candidates 2 .. 2^WIDTH-1 by trial division (one divisor
// per cycle) and streams each prime over a valid/ready port, then pulses done.
// Optional PRIME_GEN_COUNT_EN adds prime_count, the number of primes
// transferred in the current/last sweep.
module prime_gen
    import prime_pkg::*;
#(
    parameter int WIDTH = PRIME_GEN_WIDTH_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    prime_gen_if.master bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_TEST = TEST;
    localparam logic [1:0] S_EMIT = EMIT;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [WIDTH-1:0] N_MAX  = '1;
    localparam logic [WIDTH-1:0] D_INIT = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic sq_gt;
    logic divides;
    logic start_acc;
    logic xfer;

    prime_trial_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .n       (n_q),
        .d       (d_q),
        .sq_gt   (sq_gt),
        .divides (divides)
    );

    // Accepted start and completed transfer, each only meaningful in its own state.
    always_comb begin
        start_acc = (state_q == S_IDLE) && bus.start;
        xfer      = (state_q == S_EMIT) && out_valid_q && bus.out_ready;
    end

    // Sweep controller: next candidate, divisor, output register and state.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    n_d     = D_INIT;
                    d_d     = D_INIT;
                    state_d = S_TEST;
                end
            end
            S_TEST: begin
                if (sq_gt) begin
                    // No divisor found up to sqrt(n): present n downstream.
                    out_data_d  = n_q;
                    out_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else if (divides) begin
                    // Composite; end-of-range is checked before incrementing
                    // so the candidate counter never wraps.
                    if (n_q == N_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        n_d = n_q + ONE;
                        d_d = D_INIT;
                    end
                end else begin
                    d_d = d_q + ONE;
                end
            end
            S_EMIT: begin
                // out_data is held untouched until the consumer takes it.
                if (xfer) begin
                    out_valid_d = 1'b0;
                    if (n_q == N_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + ONE;
                        d_d     = D_INIT;
                        state_d = S_TEST;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Status flags are registered copies of the next state so that busy
        // and done both drop on the edge that returns to IDLE.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any sweep and drops a pending datum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef PRIME_GEN_COUNT_EN
    logic [WIDTH-1:0] count_q, count_d;

    // Transfer counter: cleared by an accepted start, kept after done.
    always_comb begin
        count_d = count_q;
        if (start_acc) begin
            count_d = '0;
        end else if (xfer) begin
            count_d = count_q + ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.prime_count = count_q;
`endif

endmodule
